rf_write_queue: RTL and testbench

- Write-side companion to the register-file bypass wrapper.
- Buffers register writebacks from the pipeline in an in-order FIFO and drains them, one per cycle, into the 8x16b register file write port (writeRegSel/writeData/writeEn).
- Exposes a pending-write lookup so decode can forward values that are still queued and not yet written.
- Sits between the writeback stage and the register file.

---
 rtl/rf_write_queue_pkg.sv | 11 +
 rtl/rf_write_queue_if.sv | 30 +++
 rtl/rf_write_queue_match.sv | 29 ++
 rtl/rf_write_queue.sv | 90 +++++++++
 tb/tb_rf_write_queue.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/rf_write_queue_pkg.sv
// Shared types for the register-file write queue: data/select widths and the queue entry layout.
package rf_write_queue_pkg;
    localparam int REG_SEL_W = 3;
    localparam int DATA_W    = 16;

    typedef struct packed {
        logic                 valid;
        logic [REG_SEL_W-1:0] regSel;
        logic [DATA_W-1:0]    data;
    } rfwqEntry_t;
endpackage

// File: rtl/rf_write_queue_if.sv
// Writeback request, register-file write port and pending-write lookup signals of rf_write_queue.
interface rf_write_queue_if #(parameter int PTR_W = 2);
    import rf_write_queue_pkg::*;

    logic                 inValid;
    logic [REG_SEL_W-1:0] inReg;
    logic [DATA_W-1:0]    inData;
    logic                 inReady;
    logic                 drainStall;
    logic [REG_SEL_W-1:0] writeRegSel;
    logic [DATA_W-1:0]    writeData;
    logic                 writeEn;
    logic [REG_SEL_W-1:0] readReg1Sel;
    logic [REG_SEL_W-1:0] readReg2Sel;
    logic                 hit1;
    logic                 hit2;
    logic [DATA_W-1:0]    fwdData1;
    logic [DATA_W-1:0]    fwdData2;
    logic [PTR_W:0]       count;

    modport master (
        output inValid, inReg, inData, drainStall, readReg1Sel, readReg2Sel,
        input  inReady, writeRegSel, writeData, writeEn, hit1, hit2, fwdData1, fwdData2, count
    );

    modport slave (
        input  inValid, inReg, inData, drainStall, readReg1Sel, readReg2Sel,
        output inReady, writeRegSel, writeData, writeEn, hit1, hit2, fwdData1, fwdData2, count
    );
endinterface

// File: rtl/rf_write_queue_match.sv
// Pending-write lookup: finds the youngest valid entry whose register equals sel.
module rfwq_match
    import rf_write_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  rfwqEntry_t [DEPTH-1:0] entries,
    input  logic [PTR_W-1:0]       tail,
    input  logic [REG_SEL_W-1:0]   sel,
    output logic                   hit,
    output logic [DATA_W-1:0]      data
);
    logic [PTR_W-1:0] idx;

    // Walk from tail (oldest slot) toward tail-1 (youngest) so the last match wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = tail + PTR_W'(i);
            if (entries[idx].valid && entries[idx].regSel == sel) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end
endmodule

// File: rtl/rf_write_queue.sv
// In-order writeback queue draining into the register-file write port, with pending-write forwarding.
// Optional same-cycle bypass of an empty queue: define RFWQ_PASSTHRU_EN.
module rf_write_queue
    import rf_write_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    rf_write_queue_if.slave   q
);
    rfwqEntry_t [DEPTH-1:0] entries;
    logic [PTR_W-1:0]       head;
    logic [PTR_W-1:0]       tail;
    logic [PTR_W:0]         cnt;

    logic notEmpty, full, passThru, push, pop;
    logic hitRaw1, hitRaw2;
    logic [DATA_W-1:0] fwdRaw1, fwdRaw2;

    assign notEmpty = (cnt != '0);
    assign full     = (cnt == (PTR_W+1)'(DEPTH));

`ifdef RFWQ_PASSTHRU_EN
    assign passThru = ~notEmpty & q.inValid & ~q.drainStall;
`else
    assign passThru = 1'b0;
`endif

    assign q.inReady = ~full;
    assign q.count   = cnt;
    assign push      = q.inValid & ~full & ~passThru;
    assign pop       = notEmpty & ~q.drainStall;

    // Outputs are forced quiet during reset so a discarded entry can never reach the file.
    always_comb begin
        q.writeEn     = 1'b0;
        q.writeRegSel = '0;
        q.writeData   = '0;
        if (!rst) begin
            if (notEmpty) begin
                q.writeEn     = pop;
                q.writeRegSel = entries[head].regSel;
                q.writeData   = entries[head].data;
            end else if (passThru) begin
                q.writeEn     = 1'b1;
                q.writeRegSel = q.inReg;
                q.writeData   = q.inData;
            end
        end
    end

    rfwq_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) uMatch1 (
        .entries(entries), .tail(tail), .sel(q.readReg1Sel), .hit(hitRaw1), .data(fwdRaw1)
    );
    rfwq_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) uMatch2 (
        .entries(entries), .tail(tail), .sel(q.readReg2Sel), .hit(hitRaw2), .data(fwdRaw2)
    );

    assign q.hit1     = hitRaw1 & ~rst;
    assign q.hit2     = hitRaw2 & ~rst;
    assign q.fwdData1 = rst ? '0 : fwdRaw1;
    assign q.fwdData2 = rst ? '0 : fwdRaw2;

    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) entries[i].valid <= 1'b0;
        end else begin
            if (push) begin
                entries[tail].valid  <= 1'b1;
                entries[tail].regSel <= q.inReg;
                entries[tail].data   <= q.inData;
                tail                 <= tail + 1'b1;
            end
            if (pop) begin
                entries[head].valid <= 1'b0;
                head                <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_rf_write_queue.sv
module tb_rf_write_queue;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rf_write_queue_if #(.PTR_W(2)) q ();
    rf_write_queue #(.DEPTH(4), .PTR_W(2)) dut (.clk(clk), .rst(rst), .q(q));

    typedef struct {
        logic        rst, v;
        logic [2:0]  r;
        logic [15:0] d;
        logic        st;
        logic [2:0]  s1, s2;
        logic        rdy, we;
        logic [2:0]  sel;
        logic [15:0] dat;
        logic        h1;
        logic [15:0] f1;
        logic        h2;
        logic [15:0] f2;
        logic [2:0]  cnt;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic r_, input logic v, input logic [2:0] r, input logic [15:0] d,
                       input logic st, input logic [2:0] s1, input logic [2:0] s2,
                       input logic rdy, input logic we, input logic [2:0] sel, input logic [15:0] dat,
                       input logic h1, input logic [15:0] f1, input logic h2, input logic [15:0] f2,
                       input logic [2:0] cnt);
        vec_t x;
        x.rst = r_; x.v = v; x.r = r; x.d = d; x.st = st; x.s1 = s1; x.s2 = s2;
        x.rdy = rdy; x.we = we; x.sel = sel; x.dat = dat;
        x.h1 = h1; x.f1 = f1; x.h2 = h2; x.f2 = f2; x.cnt = cnt;
        vecs.push_back(x);
    endtask

    function automatic logic [2:0] itemReg(input int k);
        return (k % 2 == 0) ? 3'd6 : 3'd2;
    endfunction

    initial begin
        logic [57:0] act, exp;
        logic        seen;
        int          waited;
        rst = 1'b1;
        q.inValid = 0; q.inReg = 0; q.inData = 0; q.drainStall = 0;
        q.readReg1Sel = 0; q.readReg2Sel = 0;
        repeat (2) @(posedge clk);
        #1;

        checks++;
        if (!(q.inReady === 1'b1 && q.writeEn === 1'b0 && q.writeRegSel === 3'd0 &&
              q.writeData === 16'h0 && q.hit1 === 1'b0 && q.hit2 === 1'b0 &&
              q.fwdData1 === 16'h0 && q.fwdData2 === 16'h0 && q.count === 3'd0)) begin
            errors++;
            $display("FAIL reset state: rdy=%b we=%b sel=%h dat=%h h1=%b h2=%b f1=%h f2=%h cnt=%0d",
                     q.inReady, q.writeEn, q.writeRegSel, q.writeData, q.hit1, q.hit2,
                     q.fwdData1, q.fwdData2, q.count);
        end

        //   rst v r  d        st s1 s2   rdy we sel dat      h1 f1       h2 f2       cnt
        add(0, 0, 0, 16'h0,    0, 3, 0,   1,  0, 0, 16'h0,    0, 16'h0,   0, 16'h0,   0);
`ifdef RFWQ_PASSTHRU_EN
        add(0, 1, 3, 16'h1234, 0, 3, 0,   1,  1, 3, 16'h1234, 0, 16'h0,   0, 16'h0,   0);
        add(0, 0, 0, 16'h0,    0, 3, 0,   1,  0, 0, 16'h0,    0, 16'h0,   0, 16'h0,   0);
`else
        add(0, 1, 3, 16'h1234, 0, 3, 0,   1,  0, 0, 16'h0,    0, 16'h0,   0, 16'h0,   0);
        add(0, 0, 0, 16'h0,    0, 3, 0,   1,  1, 3, 16'h1234, 1, 16'h1234,0, 16'h0,   1);
`endif
        add(0, 0, 0, 16'h0,    0, 3, 0,   1,  0, 0, 16'h0,    0, 16'h0,   0, 16'h0,   0);
        add(0, 1, 1, 16'h0001, 1, 1, 5,   1,  0, 0, 16'h0,    0, 16'h0,   0, 16'h0,   0);
        add(0, 1, 2, 16'h0002, 1, 1, 5,   1,  0, 1, 16'h0001, 1, 16'h0001,0, 16'h0,   1);
        add(0, 1, 1, 16'h00AA, 1, 1, 5,   1,  0, 1, 16'h0001, 1, 16'h0001,0, 16'h0,   2);
        add(0, 1, 4, 16'h0004, 1, 1, 5,   1,  0, 1, 16'h0001, 1, 16'h00AA,0, 16'h0,   3);
        add(0, 1, 5, 16'h5555, 1, 1, 5,   0,  0, 1, 16'h0001, 1, 16'h00AA,0, 16'h0,   4);
        add(0, 1, 5, 16'h5555, 0, 1, 4,   0,  1, 1, 16'h0001, 1, 16'h00AA,1, 16'h0004,4);
        add(0, 0, 0, 16'h0,    0, 1, 4,   1,  1, 2, 16'h0002, 1, 16'h00AA,1, 16'h0004,3);
        add(0, 0, 0, 16'h0,    0, 1, 4,   1,  1, 1, 16'h00AA, 1, 16'h00AA,1, 16'h0004,2);
        add(0, 0, 0, 16'h0,    0, 1, 4,   1,  1, 4, 16'h0004, 0, 16'h0,   1, 16'h0004,1);
        add(0, 0, 0, 16'h0,    0, 1, 5,   1,  0, 0, 16'h0,    0, 16'h0,   0, 16'h0,   0);
        add(0, 1, 6, 16'h0100, 1, 6, 2,   1,  0, 0, 16'h0,    0, 16'h0,   0, 16'h0,   0);
        add(0, 1, 2, 16'h0101, 1, 6, 2,   1,  0, 6, 16'h0100, 1, 16'h0100,0, 16'h0,   1);
        for (int j = 0; j < 10; j++) begin
            int ev, od;
            ev = (j % 2 == 0) ? j : j + 1;
            od = (j % 2 == 0) ? j + 1 : j;
            add(0, 1, itemReg(j + 2), 16'h0100 + 16'(j + 2), 0, 6, 2,
                1, 1, itemReg(j), 16'h0100 + 16'(j),
                1, 16'h0100 + 16'(ev), 1, 16'h0100 + 16'(od), 2);
        end
        add(0, 0, 0, 16'h0,    0, 6, 2,   1,  1, 6, 16'h010A, 1, 16'h010A,1, 16'h010B,2);
        add(0, 0, 0, 16'h0,    0, 6, 2,   1,  1, 2, 16'h010B, 0, 16'h0,   1, 16'h010B,1);
        add(0, 0, 0, 16'h0,    0, 6, 2,   1,  0, 0, 16'h0,    0, 16'h0,   0, 16'h0,   0);
        add(0, 1, 1, 16'h0011, 1, 1, 3,   1,  0, 0, 16'h0,    0, 16'h0,   0, 16'h0,   0);
        add(0, 1, 2, 16'h0022, 1, 1, 3,   1,  0, 1, 16'h0011, 1, 16'h0011,0, 16'h0,   1);
        add(0, 1, 3, 16'h0033, 1, 1, 3,   1,  0, 1, 16'h0011, 1, 16'h0011,0, 16'h0,   2);
        add(0, 0, 0, 16'h0,    0, 1, 3,   1,  1, 1, 16'h0011, 1, 16'h0011,1, 16'h0033,3);
        add(1, 1, 5, 16'h5555, 0, 2, 3,   1,  0, 0, 16'h0,    0, 16'h0,   0, 16'h0,   2);
        add(0, 0, 0, 16'h0,    0, 2, 5,   1,  0, 0, 16'h0,    0, 16'h0,   0, 16'h0,   0);
        add(0, 0, 0, 16'h0,    0, 3, 5,   1,  0, 0, 16'h0,    0, 16'h0,   0, 16'h0,   0);
`ifdef RFWQ_PASSTHRU_EN
        add(0, 1, 7, 16'hBEEF, 0, 7, 0,   1,  1, 7, 16'hBEEF, 0, 16'h0,   0, 16'h0,   0);
        add(0, 0, 0, 16'h0,    0, 7, 0,   1,  0, 0, 16'h0,    0, 16'h0,   0, 16'h0,   0);
`else
        add(0, 1, 7, 16'hBEEF, 0, 7, 0,   1,  0, 0, 16'h0,    0, 16'h0,   0, 16'h0,   0);
        add(0, 0, 0, 16'h0,    0, 7, 0,   1,  1, 7, 16'hBEEF, 1, 16'hBEEF,0, 16'h0,   1);
`endif
        add(0, 1, 7, 16'hBEEF, 1, 7, 0,   1,  0, 0, 16'h0,    0, 16'h0,   0, 16'h0,   0);
        add(0, 0, 0, 16'h0,    1, 7, 0,   1,  0, 7, 16'hBEEF, 1, 16'hBEEF,0, 16'h0,   1);
        add(0, 0, 0, 16'h0,    0, 7, 0,   1,  1, 7, 16'hBEEF, 1, 16'hBEEF,0, 16'h0,   1);
        add(0, 0, 0, 16'h0,    0, 7, 0,   1,  0, 0, 16'h0,    0, 16'h0,   0, 16'h0,   0);

        foreach (vecs[i]) begin
            rst           = vecs[i].rst;
            q.inValid     = vecs[i].v;
            q.inReg       = vecs[i].r;
            q.inData      = vecs[i].d;
            q.drainStall  = vecs[i].st;
            q.readReg1Sel = vecs[i].s1;
            q.readReg2Sel = vecs[i].s2;
            @(negedge clk);
            act = {q.inReady, q.writeEn, q.writeRegSel, q.writeData, q.hit1, q.fwdData1,
                   q.hit2, q.fwdData2, q.count};
            exp = {vecs[i].rdy, vecs[i].we, vecs[i].sel, vecs[i].dat, vecs[i].h1, vecs[i].f1,
                   vecs[i].h2, vecs[i].f2, vecs[i].cnt};
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL row%0d {rdy,we,sel,dat,h1,f1,h2,f2,cnt} got %h want %h", i, act, exp);
            end
            @(posedge clk);
            #1;
        end

        rst          = 1'b0;
        q.inValid    = 1'b1;
        q.inReg      = 3'd3;
        q.inData     = 16'h0033;
        q.drainStall = 1'b0;
        seen   = 1'b0;
        waited = 0;
        while (!seen && waited < 8) begin
            @(negedge clk);
            if (q.writeEn === 1'b1 && q.writeRegSel === 3'd3 && q.writeData === 16'h0033)
                seen = 1'b1;
            @(posedge clk);
            #1;
            q.inValid = 1'b0;
            waited++;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait expired: no write of R3=0x0033 within %0d cycles", waited);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
